// File: rtl/link_frame_sync.sv
// Serial link frame aligner: hunts for SYNC_BYTE, flywheels across missed syncs and emits 32-bit payloads.
// Define LINK_FRAME_SYNC_CRC_EN to check the trailing CRC-8 (poly 0x07) and pulse crc_err instead of emitting.
module link_frame_sync #(
   parameter logic [7:0]  SYNC_BYTE   = 8'hA5,
   parameter int unsigned LOCK_FRAMES = 3,
   parameter int unsigned LOSS_FRAMES = 2
) (
   input  logic        clk_sys,
   input  logic        rst,
   input  logic        bit_in,
   input  logic        bit_valid,
   output logic [31:0] data_out,
   output logic        data_valid,
   output logic        locked,
   output logic        crc_err,
   output logic [7:0]  frame_count
);

   localparam logic [3:0] LOCK_N = 4'(LOCK_FRAMES);
   localparam logic [3:0] LOSS_N = 4'(LOSS_FRAMES);

   typedef enum logic [1:0] {HUNT, RX, SYNC_CHK} state_t;

   state_t      state;
   logic [7:0]  window;
   logic [7:0]  win_next;
   logic [31:0] pay_sr;
   logic [5:0]  bit_cnt;
   logic [3:0]  good_cnt;
   logic [3:0]  miss_cnt;
   logic [3:0]  good_inc;
   logic [3:0]  miss_inc;
   logic        frame_end;
   logic        frame_ok;

   // The window shifts in every state, so at the last RX bit it holds the received CRC byte.
   always_comb begin
      win_next  = {window[6:0], bit_in};
      good_inc  = (good_cnt == 4'hF) ? good_cnt : good_cnt + 4'd1;
      miss_inc  = (miss_cnt == 4'hF) ? miss_cnt : miss_cnt + 4'd1;
      frame_end = (state == RX) && (bit_cnt == 6'd39);
   end

   always_ff @(posedge clk_sys) begin
      if (rst) begin
         state       <= HUNT;
         window      <= '0;
         pay_sr      <= '0;
         bit_cnt     <= '0;
         good_cnt    <= '0;
         miss_cnt    <= '0;
         data_out    <= '0;
         data_valid  <= 1'b0;
         locked      <= 1'b0;
         frame_count <= '0;
      end else begin
         data_valid <= 1'b0;
         if (bit_valid) begin
            window <= win_next;
            case (state)
               HUNT: begin
                  if (win_next == SYNC_BYTE) begin
                     state    <= RX;
                     bit_cnt  <= '0;
                     good_cnt <= 4'd1;
                     miss_cnt <= '0;
                     locked   <= (LOCK_N <= 4'd1);
                  end
               end
               RX: begin
                  if (bit_cnt < 6'd32)
                     pay_sr <= {pay_sr[30:0], bit_in};
                  if (frame_end) begin
                     bit_cnt <= '0;
                     state   <= SYNC_CHK;
                     if (locked && frame_ok) begin
                        data_valid  <= 1'b1;
                        data_out    <= pay_sr;
                        frame_count <= frame_count + 8'd1;
                     end
                  end else begin
                     bit_cnt <= bit_cnt + 6'd1;
                  end
               end
               SYNC_CHK: begin
                  if (bit_cnt == 6'd7) begin
                     bit_cnt <= '0;
                     if (win_next == SYNC_BYTE) begin
                        good_cnt <= good_inc;
                        miss_cnt <= '0;
                        if (good_inc >= LOCK_N)
                           locked <= 1'b1;
                        state <= RX;
                     end else if (!locked) begin
                        good_cnt <= '0;
                        window   <= '0;
                        state    <= HUNT;
                     end else begin
                        good_cnt <= '0;
                        miss_cnt <= miss_inc;
                        if (miss_inc >= LOSS_N) begin
                           locked <= 1'b0;
                           window <= '0;
                           state  <= HUNT;
                        end else begin
                           state <= RX;
                        end
                     end
                  end else begin
                     bit_cnt <= bit_cnt + 6'd1;
                  end
               end
               default: state <= HUNT;
            endcase
         end
      end
   end

`ifdef LINK_FRAME_SYNC_CRC_EN
   logic [7:0] crc_calc;
   logic [7:0] crc_next;

   always_comb
      crc_next = {crc_calc[6:0], 1'b0} ^ ((crc_calc[7] ^ bit_in) ? 8'h07 : 8'h00);

   assign frame_ok = (win_next == crc_calc);

   // Cleared on every accepted bit outside RX so each frame starts from init 0x00.
   always_ff @(posedge clk_sys) begin
      if (rst) begin
         crc_calc <= '0;
         crc_err  <= 1'b0;
      end else begin
         crc_err <= 1'b0;
         if (bit_valid) begin
            if (state != RX)
               crc_calc <= '0;
            else if (bit_cnt < 6'd32)
               crc_calc <= crc_next;
            if (frame_end)
               crc_err <= locked & ~frame_ok;
         end
      end
   end
`else
   assign frame_ok = 1'b1;
   assign crc_err  = 1'b0;
`endif

endmodule

// File: tb/tb_link_frame_sync.sv
// Bench for link_frame_sync: directed frame table, gapped-bit and wrap/reset sequences, then random
// streams checked against an index-based model of the frame stream.
module tb_link_frame_sync;

   localparam logic [7:0] SYNC = 8'hA5;
   localparam int LOCK = 3;
   localparam int LOSS = 2;
`ifdef LINK_FRAME_SYNC_CRC_EN
   localparam bit CRC_ON = 1'b1;
`else
   localparam bit CRC_ON = 1'b0;
`endif

   logic        clk_sys = 1'b0;
   logic        rst = 1'b1;
   logic        bit_in = 1'b0;
   logic        bit_valid = 1'b0;
   logic [31:0] data_out;
   logic        data_valid;
   logic        locked;
   logic        crc_err;
   logic [7:0]  frame_count;

   always #5 clk_sys = ~clk_sys;

   link_frame_sync #(
      .SYNC_BYTE  (SYNC),
      .LOCK_FRAMES(LOCK),
      .LOSS_FRAMES(LOSS)
   ) dut (
      .clk_sys    (clk_sys),
      .rst        (rst),
      .bit_in     (bit_in),
      .bit_valid  (bit_valid),
      .data_out   (data_out),
      .data_valid (data_valid),
      .locked     (locked),
      .crc_err    (crc_err),
      .frame_count(frame_count)
   );

   typedef struct {
      logic [7:0]  sync;
      logic [31:0] pay;
      logic [7:0]  crcx;
      logic        dv;
      logic        err;
      logic        lk;
   } row_t;

   typedef struct {
      logic [31:0] d;
      logic        err;
   } em_t;

   int unsigned n_vec = 0;
   int unsigned n_bad = 0;
   logic [31:0] exp_dout;
   int          exp_fc;
   logic        bits[$];
   em_t         obs[$];
   em_t         exp_q[$];
   logic        mon_en = 1'b0;
   em_t         mon_e;
   logic        m_lock;
   int          m_fc;
   row_t        rows[9];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [7:0] crc8(input logic [31:0] p);
      logic [39:0] v;
      v = {p, 8'h00};
      for (int i = 39; i >= 8; i--)
         if (v[i]) v = v ^ (40'h107 << (i - 8));
      return v[7:0];
   endfunction

   task automatic step(input logic b, input logic v);
      bit_in    = b;
      bit_valid = v;
      if (v && !rst) bits.push_back(b);
      @(posedge clk_sys);
      #1;
   endtask

   task automatic send_bits(input logic [31:0] val, input int n);
      for (int i = n - 1; i >= 0; i--) step(val[i], 1'b1);
   endtask

   task automatic send_frame(input logic [7:0] s, input logic [31:0] p, input logic [7:0] x);
      send_bits({24'h0, s}, 8);
      send_bits(p, 32);
      send_bits({24'h0, crc8(p) ^ x}, 8);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      repeat (3) step(1'($urandom), 1'b1);
      rst = 1'b0;
      exp_dout = '0;
      exp_fc   = 0;
      bits.delete();
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_data_out"}, data_out, 32'h0);
      check({tag, "_data_valid"}, {31'h0, data_valid}, 32'h0);
      check({tag, "_locked"}, {31'h0, locked}, 32'h0);
      check({tag, "_crc_err"}, {31'h0, crc_err}, 32'h0);
      check({tag, "_frame_count"}, {24'h0, frame_count}, 32'h0);
   endtask

   task automatic run_rows(input int first, input int last);
      for (int r = first; r <= last; r++) begin
         send_frame(rows[r].sync, rows[r].pay, rows[r].crcx);
         if (rows[r].dv) begin
            exp_dout = rows[r].pay;
            exp_fc++;
         end
         check($sformatf("row%0d_data_valid", r), {31'h0, data_valid}, {31'h0, rows[r].dv});
         check($sformatf("row%0d_crc_err", r), {31'h0, crc_err}, {31'h0, rows[r].err});
         check($sformatf("row%0d_locked", r), {31'h0, locked}, {31'h0, rows[r].lk});
         check($sformatf("row%0d_data_out", r), data_out, exp_dout);
         check($sformatf("row%0d_frame_count", r), {24'h0, frame_count}, 32'(exp_fc % 256));
      end
   endtask

   always @(negedge clk_sys) begin
      if (mon_en) begin
         if (data_valid) begin
            mon_e.d   = data_out;
            mon_e.err = 1'b0;
            obs.push_back(mon_e);
         end
         if (crc_err) begin
            mon_e.d   = 32'h0;
            mon_e.err = 1'b1;
            obs.push_back(mon_e);
         end
      end
   end

   // Byte ending at accepted-bit index j; bits before the hunt start s read as zero (cleared window).
   function automatic logic [7:0] byte_at(input int s, input int j);
      logic [7:0] v;
      v = '0;
      for (int k = 0; k < 8; k++)
         v = {v[6:0], (j - 7 + k >= s) ? bits[j - 7 + k] : 1'b0};
      return v;
   endfunction

   function automatic logic [31:0] field(input int idx, input int n);
      logic [31:0] v;
      v = '0;
      for (int k = 0; k < n; k++) v = {v[30:0], bits[idx + k]};
      return v;
   endfunction

   task automatic run_model();
      int n, fs, hs, good, miss;
      bit hunting, lk;
      logic [31:0] pay;
      logic [7:0] rc, sb;
      em_t e;
      n = bits.size();
      fs = 0; hs = 0; good = 0; miss = 0; hunting = 1'b1; lk = 1'b0;
      exp_q.delete();
      m_fc = 0;
      forever begin
         if (hunting) begin
            fs = -1;
            for (int j = hs; j < n; j++)
               if (byte_at(hs, j) == SYNC) begin
                  fs = j + 1;
                  break;
               end
            if (fs < 0) break;
            hunting = 1'b0; good = 1; miss = 0; lk = (LOCK == 1);
         end
         if (fs + 40 > n) break;
         pay = field(fs, 32);
         rc  = 8'(field(fs + 32, 8));
         if (lk) begin
            if (CRC_ON && rc != crc8(pay)) begin
               e.d = 32'h0; e.err = 1'b1;
            end else begin
               e.d = pay; e.err = 1'b0;
               m_fc++;
            end
            exp_q.push_back(e);
         end
         if (fs + 48 > n) break;
         sb = 8'(field(fs + 40, 8));
         if (sb == SYNC) begin
            good = (good < 15) ? good + 1 : 15;
            miss = 0;
            if (good >= LOCK) lk = 1'b1;
            fs += 48;
         end else if (!lk) begin
            good = 0; hunting = 1'b1; hs = fs + 48;
         end else begin
            good = 0; miss++;
            if (miss >= LOSS) begin
               lk = 1'b0; hunting = 1'b1; hs = fs + 48;
            end else begin
               fs += 48;
            end
         end
      end
      m_lock = lk;
   endtask

   function automatic bit garbage_ok(input logic [4:0] g);
      logic [20:0] s;
      s = {8'h00, g, SYNC};
      for (int j = 0; j < 12; j++)
         if (s[12 - j +: 8] == SYNC) return 1'b0;
      return 1'b1;
   endfunction

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      logic [4:0]  g;
      logic [31:0] p;
      logic [47:0] fr;

      rows[0] = '{SYNC,  32'h00000001, 8'h00, 1'b0, 1'b0, 1'b0};
      rows[1] = '{SYNC,  32'h00000002, 8'h00, 1'b0, 1'b0, 1'b0};
      rows[2] = '{SYNC,  32'h00000003, 8'h00, 1'b1, 1'b0, 1'b1};
      rows[3] = '{SYNC,  32'h00000004, 8'h00, 1'b1, 1'b0, 1'b1};
      rows[4] = '{8'h5A, 32'h11111111, 8'h00, 1'b1, 1'b0, 1'b1};
      rows[5] = '{SYNC,  32'h22222222, 8'h00, 1'b1, 1'b0, 1'b1};
      rows[6] = '{SYNC,  32'hDEADBEEF, 8'h01, !CRC_ON, CRC_ON, 1'b1};
      rows[7] = '{8'h5A, 32'h33333333, 8'h00, 1'b1, 1'b0, 1'b1};
      rows[8] = '{8'h5A, 32'h44444444, 8'h00, 1'b0, 1'b0, 1'b0};

      do_reset();
      check_zero("reset");
      run_rows(0, 8);

      // Garbage prefix, then lock at a 5-bit offset.
      do_reset();
      do g = 5'($urandom); while (!garbage_ok(g));
      send_bits({27'h0, g}, 5);
      run_rows(0, 3);

      // Locked frame delivered one accepted bit every three cycles.
      p  = $urandom;
      fr = {SYNC, p, crc8(p)};
      for (int i = 47; i >= 0; i--) begin
         if (i == 0) check("gap_early_valid", {31'h0, data_valid}, 32'h0);
         step(fr[i], 1'b1);
         if (i != 0) begin
            step(1'($urandom), 1'b0);
            step(1'($urandom), 1'b0);
         end
      end
      check("gap_data_valid", {31'h0, data_valid}, 32'h1);
      check("gap_data_out", data_out, p);
      check("gap_frame_count", {24'h0, frame_count}, 32'd3);
      step(1'($urandom), 1'b0);
      check("gap_pulse_width", {31'h0, data_valid}, 32'h0);
      check("gap_data_hold", data_out, p);

      // 302 frames: the last 300 are emitted, frame_count wraps to 44.
      do_reset();
      for (int i = 0; i < 302; i++) send_frame(SYNC, 32'(i), 8'h00);
      check("wrap_frame_count", {24'h0, frame_count}, 32'd44);
      check("wrap_locked", {31'h0, locked}, 32'h1);
      check("wrap_data_out", data_out, 32'd301);
      send_bits(32'h5A5A5, 20);
      rst = 1'b1;
      step(1'($urandom), 1'b1);
      check_zero("midrst");
      rst = 1'b0;
      exp_dout = '0;
      exp_fc   = 0;
      run_rows(0, 3);

      // Randomised streams against the reference model.
      for (int t = 0; t < 4; t++) begin
         do_reset();
         obs.delete();
         mon_en = 1'b1;
         for (int f = 0; f < 50; f++) begin
            logic [7:0] s, x;
            if ($urandom_range(7) == 0) begin
               int ng;
               ng = int'($urandom_range(7, 1));
               for (int k = 0; k < ng; k++) step(1'($urandom), 1'b1);
            end
            s  = ($urandom_range(4) == 0) ? 8'($urandom) : SYNC;
            p  = $urandom;
            x  = ($urandom_range(7) == 0) ? 8'($urandom_range(255, 1)) : 8'h00;
            fr = {s, p, crc8(p) ^ x};
            for (int i = 47; i >= 0; i--) begin
               while ($urandom_range(3) == 0) step(1'($urandom), 1'b0);
               step(fr[i], 1'b1);
            end
         end
         step(1'b0, 1'b0);
         step(1'b0, 1'b0);
         mon_en = 1'b0;
         run_model();
         check($sformatf("rand%0d_emit_count", t), obs.size(), exp_q.size());
         for (int i = 0; i < obs.size() && i < exp_q.size(); i++) begin
            check($sformatf("rand%0d_emit%0d_err", t, i), {31'h0, obs[i].err}, {31'h0, exp_q[i].err});
            check($sformatf("rand%0d_emit%0d_data", t, i), obs[i].d, exp_q[i].d);
         end
         check($sformatf("rand%0d_locked", t), {31'h0, locked}, {31'h0, m_lock});
         check($sformatf("rand%0d_frame_count", t), {24'h0, frame_count}, 32'(m_fc % 256));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
